// File: rtl/color_classifier_pkg.sv
// Shared encodings for the colour-sensor front end: filter-select codes,
// published colour codes, scan FSM states and the channel classifier.
package color_pkg;

  localparam logic [1:0] RED_FILTER   = 2'd0;
  localparam logic [1:0] BLUE_FILTER  = 2'd1;
  localparam logic [1:0] CLEAR_FILTER = 2'd2;
  localparam logic [1:0] GREEN_FILTER = 2'd3;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam logic [1:0] BLUE  = 2'd3;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, EVAL} state_t;

  // Exactly one high channel names a colour; white, black or two-high is NONE.
  function automatic logic [1:0] classify(input logic hi_r, input logic hi_g, input logic hi_b);
    case ({hi_r, hi_g, hi_b})
      3'b100:  return RED;
      3'b010:  return GREEN;
      3'b001:  return BLUE;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/color_classifier_edge_counter.sv
// Synchronises the sensor frequency output, detects rising edges and counts
// them in a saturating counter; count_next already includes this cycle's edge.
module edge_counter #(
  parameter int COUNT_W = 14
) (
  input  logic               clk_1MHz,
  input  logic               rst,
  input  logic               sig_async,
  input  logic               clear,
  input  logic               count_en,
  output logic [COUNT_W-1:0] count_next
);

  logic [1:0]         sync_reg;
  logic               prev_reg;
  logic               rise;
  logic [COUNT_W-1:0] count_reg;

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sig_async};
      prev_reg <= sync_reg[1];
    end
  end

  assign rise = sync_reg[1] & ~prev_reg;

  always_comb begin
    count_next = count_reg;
    if (count_en && rise && (count_reg != '1))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst)        count_reg <= '0;
    else if (clear) count_reg <= '0;
    else            count_reg <= count_next;
  end

endmodule

// File: rtl/color_classifier.sv
// TCS3200-style colour front end: scans red/green/blue filters, classifies the
// window counts and publishes a debounced colour. Optional: COLOR_ONESHOT_EN.
module color_classifier
  import color_pkg::*;
#(
  parameter int         WINDOW_CYCLES = 10000,
  parameter int         SETTLE_CYCLES = 100,
  parameter int         COUNT_W       = 14,
  parameter int         THRESH        = 100,
  parameter int         CONFIRM       = 2,
  parameter int         ARM_CYCLES    = 1000000,
  parameter logic [1:0] SCALER        = 2'd2
) (
  input  logic               clk_1MHz,
  input  logic               rst,
  input  logic               cs_out,
  input  logic               en,
  output logic [1:0]         filter,
  output logic [1:0]         cs_scaler,
  output logic [1:0]         color,
  output logic               color_valid,
  output logic [COUNT_W-1:0] red_cnt,
  output logic [COUNT_W-1:0] green_cnt,
  output logic [COUNT_W-1:0] blue_cnt
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ARM_W   = $clog2(ARM_CYCLES + 1);

  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [ARM_W-1:0]   ARM_MAX     = ARM_W'(ARM_CYCLES);
  localparam logic [COUNT_W-1:0] THRESH_C    = COUNT_W'(THRESH);
  localparam logic [3:0]         CONFIRM_C   = 4'(CONFIRM);

  state_t             state_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [ARM_W-1:0]   arm_reg;
  logic [3:0]         conf_reg;
  logic [3:0]         conf_next;
  logic [1:0]         prev_cand_reg;
  logic [1:0]         cand;
  logic [1:0]         filter_reg;
  logic [1:0]         color_reg;
  logic               color_valid_reg;
  logic [COUNT_W-1:0] red_cnt_reg;
  logic [COUNT_W-1:0] green_cnt_reg;
  logic [COUNT_W-1:0] blue_cnt_reg;
  logic [COUNT_W-1:0] win_total;
  logic               counting;
  logic               blocked;
  logic               do_update;

  assign counting = (state_reg == COUNT);

  edge_counter #(
    .COUNT_W (COUNT_W)
  ) u_edge_counter (
    .clk_1MHz   (clk_1MHz),
    .rst        (rst),
    .sig_async  (cs_out),
    .clear      (!counting),
    .count_en   (counting),
    .count_next (win_total)
  );

  assign cand = classify(red_cnt_reg >= THRESH_C, green_cnt_reg >= THRESH_C,
                         blue_cnt_reg >= THRESH_C);

  always_comb begin
    conf_next = 4'd1;
    if (cand == prev_cand_reg)
      conf_next = (conf_reg == 4'hF) ? conf_reg : conf_reg + 4'd1;
  end

  assign do_update = (state_reg == EVAL) && en && (cand != NONE) &&
                     (conf_next >= CONFIRM_C) && (arm_reg >= ARM_MAX) &&
                     (cand != color_reg) && !blocked;

`ifdef COLOR_ONESHOT_EN
  // One colour update per en-high interval; dropping en re-opens the gate.
  logic lock_reg;

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst)            lock_reg <= 1'b0;
    else if (!en)       lock_reg <= 1'b0;
    else if (do_update) lock_reg <= 1'b1;
  end

  assign blocked = lock_reg;
`else
  assign blocked = 1'b0;
`endif

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst)                    arm_reg <= '0;
    else if (!en)               arm_reg <= '0;
    else if (arm_reg != ARM_MAX) arm_reg <= arm_reg + 1'b1;
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      filter_reg      <= RED_FILTER;
      conf_reg        <= '0;
      prev_cand_reg   <= NONE;
      color_reg       <= NONE;
      color_valid_reg <= 1'b0;
      red_cnt_reg     <= '0;
      green_cnt_reg   <= '0;
      blue_cnt_reg    <= '0;
    end else begin
      color_valid_reg <= 1'b0;
      if (!en) begin
        // Abandon the round; published counts and colour are kept.
        state_reg     <= IDLE;
        timer_reg     <= '0;
        filter_reg    <= RED_FILTER;
        conf_reg      <= '0;
        prev_cand_reg <= NONE;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg  <= SETTLE;
            timer_reg  <= '0;
            filter_reg <= RED_FILTER;
          end
          SETTLE: begin
            if (timer_reg == SETTLE_LAST) begin
              state_reg <= COUNT;
              timer_reg <= '0;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          COUNT: begin
            if (timer_reg == WINDOW_LAST) begin
              timer_reg <= '0;
              case (filter_reg)
                RED_FILTER: begin
                  red_cnt_reg <= win_total;
                  filter_reg  <= GREEN_FILTER;
                  state_reg   <= SETTLE;
                end
                GREEN_FILTER: begin
                  green_cnt_reg <= win_total;
                  filter_reg    <= BLUE_FILTER;
                  state_reg     <= SETTLE;
                end
                default: begin
                  blue_cnt_reg <= win_total;
                  state_reg    <= EVAL;
                end
              endcase
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          EVAL: begin
            state_reg  <= SETTLE;
            timer_reg  <= '0;
            filter_reg <= RED_FILTER;
            // A NONE round holds both the streak and the published colour.
            if (cand != NONE) begin
              conf_reg      <= conf_next;
              prev_cand_reg <= cand;
            end
            if (do_update) begin
              color_reg       <= cand;
              color_valid_reg <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign filter      = filter_reg;
  assign cs_scaler   = SCALER;
  assign color       = color_reg;
  assign color_valid = color_valid_reg;
  assign red_cnt     = red_cnt_reg;
  assign green_cnt   = green_cnt_reg;
  assign blue_cnt    = blue_cnt_reg;

endmodule

// File: tb/tb_color_classifier.sv
// Table-driven bench for color_classifier: per-round filter periods with
// hand-computed counts/colour, plus en-drop, saturation and async-reset sequences.
module tb_color_classifier;

`ifdef COLOR_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  localparam logic [1:0] F_RED   = 2'd0;
  localparam logic [1:0] F_BLUE  = 2'd1;
  localparam logic [1:0] F_GREEN = 2'd3;

  logic       clk_1MHz;
  logic       rst;
  logic       cs_out;
  logic       en;
  logic [1:0] filter, cs_scaler, color;
  logic       color_valid;
  logic [7:0] red_cnt, green_cnt, blue_cnt;

  logic       cs_b;
  logic       en_b;
  logic [1:0] filter_b, cs_scaler_b, color_b;
  logic       color_valid_b;
  logic [3:0] red_cnt_b, green_cnt_b, blue_cnt_b;

  color_classifier #(
    .WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(8), .THRESH(10),
    .CONFIRM(2), .ARM_CYCLES(50), .SCALER(2'd2)
  ) dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .cs_out(cs_out), .en(en),
    .filter(filter), .cs_scaler(cs_scaler), .color(color), .color_valid(color_valid),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt)
  );

  color_classifier #(
    .WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(4), .THRESH(10),
    .CONFIRM(2), .ARM_CYCLES(50), .SCALER(2'd2)
  ) dut_sat (
    .clk_1MHz(clk_1MHz), .rst(rst), .cs_out(cs_b), .en(en_b),
    .filter(filter_b), .cs_scaler(cs_scaler_b), .color(color_b), .color_valid(color_valid_b),
    .red_cnt(red_cnt_b), .green_cnt(green_cnt_b), .blue_cnt(blue_cnt_b)
  );

  initial clk_1MHz = 1'b0;
  always #5 clk_1MHz = ~clk_1MHz;

  // Sensor model: per-filter period, phase restarts on each filter change, low half first.
  int         p = 0;
  int         per_r = 4, per_g = 40, per_b = 40;
  int         per_cur;
  logic [1:0] last_filter = 2'd0;

  always @(negedge clk_1MHz) begin
    if (filter != last_filter) p = 0;
    else                       p = p + 1;
    last_filter = filter;
  end

  assign per_cur = (filter == F_RED) ? per_r : (filter == F_GREEN) ? per_g : per_b;
  assign cs_out  = (p % per_cur) >= (per_cur / 2);

  initial cs_b = 1'b0;
  always @(negedge clk_1MHz) cs_b = ~cs_b;

  int vp_cnt = 0;
  always @(negedge clk_1MHz) if (color_valid) vp_cnt++;

  int checks = 0;
  int failures = 0;
  int exp_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_filter(input logic [1:0] v, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_1MHz);
      n++;
    end while (filter != v && n < budget);
    if (filter != v) begin
      checks++;
      failures++;
      $display("FAIL wait_filter: filter=%0d never reached %0d within %0d cycles", filter, v, budget);
    end
  endtask

  // Returns just after the negedge that follows EVAL (new round's red settle).
  task automatic wait_round_end();
    wait_filter(F_BLUE, 1000);
    wait_filter(F_RED, 1000);
    #1;
  endtask

  typedef struct {
    int per_r, per_g, per_b;
    bit chk_cnt;
    int exp_r, exp_g, exp_b;
    int exp_color;
    int exp_valid;
  } row_t;

  row_t rows [13];

  task automatic run_row(input int i);
    per_r = rows[i].per_r;
    per_g = rows[i].per_g;
    per_b = rows[i].per_b;
    wait_round_end();
    if (rows[i].chk_cnt) begin
      chk($sformatf("row%0d red_cnt", i), red_cnt, rows[i].exp_r);
      chk($sformatf("row%0d green_cnt", i), green_cnt, rows[i].exp_g);
      chk($sformatf("row%0d blue_cnt", i), blue_cnt, rows[i].exp_b);
    end
    chk($sformatf("row%0d color", i), color, rows[i].exp_color);
    chk($sformatf("row%0d color_valid", i), color_valid, rows[i].exp_valid);
    exp_pulses += rows[i].exp_valid;
    chk($sformatf("row%0d pulse_total", i), vp_cnt, exp_pulses);
  endtask

  initial begin
    // Rows 0-6 share one en interval; rows 7-12 follow an en drop.
    rows[0]  = '{4, 40, 40, 1'b1, 25, 3, 3, 0, 0};
    rows[1]  = '{4, 40, 40, 1'b1, 25, 3, 3, 1, 1};
    rows[2]  = '{40, 4, 40, 1'b1, 3, 25, 3, 1, 0};
    rows[3]  = '{40, 40, 4, 1'b1, 3, 3, 25, 1, 0};
    rows[4]  = '{40, 4, 40, 1'b1, 3, 25, 3, 1, 0};
    rows[5]  = '{40, 40, 4, 1'b1, 3, 3, 25, 1, 0};
    rows[6]  = '{40, 40, 4, 1'b1, 3, 3, 25, ONESHOT ? 1 : 3, ONESHOT ? 0 : 1};
    rows[7]  = '{40, 40, 4, 1'b0, 0, 0, 0, ONESHOT ? 1 : 3, 0};
    rows[8]  = '{40, 40, 4, 1'b1, 3, 3, 25, 3, ONESHOT ? 1 : 0};
    rows[9]  = '{4, 4, 4, 1'b1, 25, 25, 25, 3, 0};
    rows[10] = '{40, 40, 40, 1'b1, 3, 3, 3, 3, 0};
    rows[11] = '{4, 40, 40, 1'b1, 25, 3, 3, 3, 0};
    rows[12] = '{4, 40, 40, 1'b1, 25, 3, 3, ONESHOT ? 3 : 1, ONESHOT ? 0 : 1};

    rst = 1'b1;
    en = 1'b0;
    en_b = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    chk("reset filter", filter, 0);
    chk("reset cs_scaler", cs_scaler, 2);
    chk("reset color", color, 0);
    chk("reset color_valid", color_valid, 0);
    chk("reset red_cnt", red_cnt, 0);
    chk("reset green_cnt", green_cnt, 0);
    chk("reset blue_cnt", blue_cnt, 0);
    rst = 1'b0;
    @(negedge clk_1MHz);
    en_b = 1'b1;
    en = 1'b1;

    for (int i = 0; i <= 6; i++) run_row(i);

    // Saturating instance has seen at least one full round of period-2 input.
    chk("sat red_cnt", red_cnt_b, 15);
    chk("sat green_cnt", green_cnt_b, 15);
    chk("sat blue_cnt", blue_cnt_b, 15);
    chk("sat color", color_b, 0);

    // Drop en at cycle 50 of the green counting window.
    per_r = 4; per_g = 40; per_b = 40;
    wait_filter(F_GREEN, 1000);
    repeat (54) @(negedge clk_1MHz);
    en = 1'b0;
    @(negedge clk_1MHz);
    chk("en_drop filter", filter, 0);
    chk("en_drop red_cnt", red_cnt, 25);
    chk("en_drop green_cnt", green_cnt, 3);
    chk("en_drop blue_cnt", blue_cnt, 25);
    chk("en_drop color", color, ONESHOT ? 1 : 3);
    repeat (20) @(negedge clk_1MHz);
    chk("idle filter", filter, 0);
    chk("idle green_cnt", green_cnt, 3);
    chk("idle pulse_total", vp_cnt, exp_pulses);
    en = 1'b1;

    for (int i = 7; i <= 12; i++) run_row(i);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst color", color, 0);
    chk("async_rst color_valid", color_valid, 0);
    chk("async_rst filter", filter, 0);
    chk("async_rst red_cnt", red_cnt, 0);
    chk("async_rst blue_cnt", blue_cnt, 0);
    chk("async_rst sat red_cnt", red_cnt_b, 0);
    @(negedge clk_1MHz);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
